// File: rtl/spi_cmdq_pkg.sv
// spi_cmdq_pkg: shared types and constants for the SPI command queue.
//   state_t  - sequencer FSM state encoding (2-bit)
//   rd_bit() - position of the read flag inside a command FIFO entry
//   wd_max() - all-ones terminal value of the completion watchdog
package spi_cmdq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Command entry is {rd, data}; the read flag sits just above the data word.
    function automatic int rd_bit(input int data_width);
        return data_width;
    endfunction

    function automatic longint unsigned wd_max(input int bits);
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/axis_spi_cmdq_if.sv
// axis_spi_cmdq_if: bundle of all handshake/bus signals of axis_spi_cmdq.
//   slave  - view taken by the command queue itself
//   master - view taken by the host / SPI master / readback consumer
//   command push  : s_cmd_data, s_cmd_rd, s_cmd_valid, s_cmd_ready
//   SPI write     : m_spi_wdata, m_spi_wvalid, m_spi_wready
//   SPI completion: spi_rdata, spi_done_valid, spi_done_ready
//   readback pop  : m_rb_data, m_rb_valid, m_rb_ready
//   status        : cmd_level, busy, timeout_err, err_clr
interface axis_spi_cmdq_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH_LOG2 = 4
);
    logic [DATA_WIDTH-1:0]     s_cmd_data;
    logic                      s_cmd_rd;
    logic                      s_cmd_valid;
    logic                      s_cmd_ready;
    logic [DATA_WIDTH-1:0]     m_spi_wdata;
    logic                      m_spi_wvalid;
    logic                      m_spi_wready;
    logic [DATA_WIDTH-1:0]     spi_rdata;
    logic                      spi_done_valid;
    logic                      spi_done_ready;
    logic [DATA_WIDTH-1:0]     m_rb_data;
    logic                      m_rb_valid;
    logic                      m_rb_ready;
    logic [CMD_DEPTH_LOG2:0]   cmd_level;
    logic                      busy;
    logic                      timeout_err;
    logic                      err_clr;

    modport slave (
        input  s_cmd_data, s_cmd_rd, s_cmd_valid, m_spi_wready, spi_rdata,
               spi_done_valid, m_rb_ready, err_clr,
        output s_cmd_ready, m_spi_wdata, m_spi_wvalid, spi_done_ready,
               m_rb_data, m_rb_valid, cmd_level, busy, timeout_err
    );

    modport master (
        output s_cmd_data, s_cmd_rd, s_cmd_valid, m_spi_wready, spi_rdata,
               spi_done_valid, m_rb_ready, err_clr,
        input  s_cmd_ready, m_spi_wdata, m_spi_wvalid, spi_done_ready,
               m_rb_data, m_rb_valid, cmd_level, busy, timeout_err
    );

endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through FIFO with occupancy.
//   clk, rst_n - clock, asynchronous active-low reset
//   push/wdata - write strobe and data (caller never pushes when full)
//   pop        - read strobe (caller never pops when empty)
//   rdata      - head entry, forced to zero while empty
//   level      - occupancy 0..2**DEPTH_LOG2
module axis_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   level
);

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + DEPTH_LOG2'(1);
            if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
            if (push && !pop)      level <= level + (DEPTH_LOG2+1)'(1);
            else if (pop && !push) level <= level - (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Stale storage is hidden so the head reads zero out of reset and when drained.
    assign rdata = (level == '0) ? '0 : mem[rptr];

endmodule

// File: rtl/axis_spi_cmdq.sv
// axis_spi_cmdq: command queue and sequencer in front of the axis_spi master.
//   axis_clk    - clock, rising edge
//   axis_resetn - asynchronous active-low reset
//   bus         - slave view of axis_spi_cmdq_if: command push stream,
//                 SPI write stream, SPI completion, readback pop stream,
//                 cmd_level / busy / timeout_err status and err_clr.
module axis_spi_cmdq
    import spi_cmdq_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH_LOG2 = 4,
    parameter int RB_DEPTH_LOG2  = 3,
    parameter int TIMEOUT_BITS   = 16
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    axis_spi_cmdq_if.slave        bus
);

    localparam int RD = rd_bit(DATA_WIDTH);
    localparam logic [TIMEOUT_BITS-1:0] WD_MAX = TIMEOUT_BITS'(wd_max(TIMEOUT_BITS));

    state_t                  state, state_nx;
    logic [DATA_WIDTH:0]     cmd_head;
    logic [CMD_DEPTH_LOG2:0] cmd_lvl;
    logic                    cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [DATA_WIDTH-1:0]   rb_head;
    logic [RB_DEPTH_LOG2:0]  rb_lvl;
    logic                    rb_empty, rb_full, rb_push, rb_pop;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    cur_rd;
    logic [TIMEOUT_BITS-1:0] wd, wd_nxt;
    logic                    timeout, err;

    assign cmd_empty = (cmd_lvl == '0);
    assign cmd_full  = cmd_lvl[CMD_DEPTH_LOG2];
    assign cmd_push  = bus.s_cmd_valid && !cmd_full;
    assign rb_empty  = (rb_lvl == '0);
    assign rb_full   = rb_lvl[RB_DEPTH_LOG2];
    assign rb_pop    = bus.m_rb_ready && !rb_empty;
    assign wd_nxt    = wd + TIMEOUT_BITS'(1);

    axis_sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH_LOG2(CMD_DEPTH_LOG2)) u_cmd_fifo (
        .clk   (axis_clk),
        .rst_n (axis_resetn),
        .push  (cmd_push),
        .wdata ({bus.s_cmd_rd, bus.s_cmd_data}),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .level (cmd_lvl)
    );

    axis_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(RB_DEPTH_LOG2)) u_rb_fifo (
        .clk   (axis_clk),
        .rst_n (axis_resetn),
        .push  (rb_push),
        .wdata (bus.spi_rdata),
        .pop   (rb_pop),
        .rdata (rb_head),
        .level (rb_lvl)
    );

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state   <= IDLE;
            wdata_q <= '0;
            cur_rd  <= 1'b0;
            wd      <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (cmd_pop) begin
                wdata_q <= cmd_head[DATA_WIDTH-1:0];
                cur_rd  <= cmd_head[RD];
            end
            wd  <= (state == WAIT_DONE) ? wd_nxt : '0;
            err <= timeout ? 1'b1 : (bus.err_clr ? 1'b0 : err);
        end
    end

    // A read is only launched when its readback has a guaranteed slot, so the
    // readback FIFO can never overflow with a single transaction in flight.
    always_comb begin
        state_nx = state;
        cmd_pop  = 1'b0;
        rb_push  = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && (!cmd_head[RD] || !rb_full)) begin
                    cmd_pop  = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_spi_wready) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.spi_done_valid) begin
                    rb_push  = cur_rd;
                    state_nx = IDLE;
                end else if (wd_nxt == WD_MAX) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.s_cmd_ready    = !cmd_full;
    assign bus.m_spi_wdata    = wdata_q;
    assign bus.m_spi_wvalid   = (state == ISSUE);
    assign bus.spi_done_ready = (state == WAIT_DONE);
    assign bus.m_rb_data      = rb_head;
    assign bus.m_rb_valid     = !rb_empty;
    assign bus.cmd_level      = cmd_lvl;
    assign bus.busy           = (state != IDLE) || !cmd_empty;
    assign bus.timeout_err    = err;

endmodule

// File: tb/tb_axis_spi_cmdq.sv
// tb_axis_spi_cmdq: directed self-checking bench for axis_spi_cmdq with a
// task-based stand-in for the downstream axis_spi master.
module tb_axis_spi_cmdq;

    logic axis_clk    = 1'b0;
    logic axis_resetn = 1'b0;
    int   checks      = 0;
    int   errors      = 0;

    always #5 axis_clk = ~axis_clk;

    axis_spi_cmdq_if #(.DATA_WIDTH(32), .CMD_DEPTH_LOG2(4)) bus ();

    axis_spi_cmdq #(
        .DATA_WIDTH     (32),
        .CMD_DEPTH_LOG2 (4),
        .RB_DEPTH_LOG2  (3),
        .TIMEOUT_BITS   (4)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_resetn (axis_resetn),
        .bus         (bus)
    );

    task automatic push_cmd(input logic [31:0] d, input logic rd);
        int n = 0;
        bus.s_cmd_data  = d;
        bus.s_cmd_rd    = rd;
        bus.s_cmd_valid = 1'b1;
        while (!bus.s_cmd_ready && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        @(negedge axis_clk);
        bus.s_cmd_valid = 1'b0;
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL push_wait: s_cmd_ready stayed %0b, required 1 within 200 cycles", bus.s_cmd_ready);
        end
    endtask

    task automatic wait_wvalid();
        int n = 0;
        while (!bus.m_spi_wvalid && n < 100) begin
            @(negedge axis_clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wvalid_wait: m_spi_wvalid stayed %0b, required 1 within 100 cycles", bus.m_spi_wvalid);
        end
    endtask

    // Stand-in SPI master: accept one word, complete it 4 cycles later with rd_word.
    task automatic serve(input logic [31:0] rd_word, output logic [31:0] word, output logic rbv);
        wait_wvalid();
        word = bus.m_spi_wdata;
        bus.m_spi_wready = 1'b1;
        @(negedge axis_clk);
        bus.m_spi_wready = 1'b0;
        repeat (3) @(negedge axis_clk);
        bus.spi_rdata      = rd_word;
        bus.spi_done_valid = 1'b1;
        rbv = bus.m_rb_valid;
        @(negedge axis_clk);
        bus.spi_done_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.s_cmd_ready !== 1'b1 || bus.m_spi_wvalid !== 1'b0 || bus.m_spi_wdata !== 32'h0 ||
            bus.spi_done_ready !== 1'b0 || bus.m_rb_valid !== 1'b0 || bus.m_rb_data !== 32'h0 ||
            bus.cmd_level !== 5'd0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b wvalid=%b wdata=%h done_ready=%b rb_valid=%b rb_data=%h level=%0d busy=%b err=%b, required 1 0 0 0 0 0 0 0 0",
                     bus.s_cmd_ready, bus.m_spi_wvalid, bus.m_spi_wdata, bus.spi_done_ready, bus.m_rb_valid,
                     bus.m_rb_data, bus.cmd_level, bus.busy, bus.timeout_err);
        end
    endtask

    task automatic test_writes();
        logic [31:0] exp_w [3] = '{32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        logic [31:0] w;
        logic        b;
        push_cmd(exp_w[0], 1'b0);
        checks++;
        if (bus.m_spi_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL wvalid_n1: got %b, required 0", bus.m_spi_wvalid);
        end
        push_cmd(exp_w[1], 1'b0);
        checks++;
        if (bus.m_spi_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL wvalid_n2: got %b, required 1", bus.m_spi_wvalid);
        end
        push_cmd(exp_w[2], 1'b0);
        for (int i = 0; i < 3; i++) begin
            serve(32'h0, w, b);
            checks++;
            if (w !== exp_w[i]) begin
                errors++;
                $display("FAIL write_word%0d: got %h, required %h", i, w, exp_w[i]);
            end
            if (i == 0) begin
                checks++;
                if (bus.m_spi_wvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: wvalid got %b, required 0", bus.m_spi_wvalid);
                end
                @(negedge axis_clk);
                checks++;
                if (bus.m_spi_wvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rise: wvalid got %b, required 1", bus.m_spi_wvalid);
                end
            end
            if (i == 1) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid: got %b, required 1", bus.busy);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.m_rb_valid !== 1'b0) begin
            errors++;
            $display("FAIL writes_end: busy=%b rb_valid=%b, required 0 0", bus.busy, bus.m_rb_valid);
        end
    endtask

    task automatic test_read();
        logic [31:0] w;
        logic        b;
        push_cmd(32'h8012_0000, 1'b1);
        serve(32'h0000_5A5A, w, b);
        checks++;
        if (w !== 32'h8012_0000 || b !== 1'b0) begin
            errors++;
            $display("FAIL read_issue: word=%h rb_valid_at_done=%b, required 80120000 0", w, b);
        end
        checks++;
        if (bus.m_rb_valid !== 1'b1 || bus.m_rb_data !== 32'h0000_5A5A) begin
            errors++;
            $display("FAIL read_capture: valid=%b data=%h, required 1 00005a5a", bus.m_rb_valid, bus.m_rb_data);
        end
        bus.m_rb_ready = 1'b1;
        @(negedge axis_clk);
        bus.m_rb_ready = 1'b0;
        checks++;
        if (bus.m_rb_valid !== 1'b0 || bus.m_rb_data !== 32'h0) begin
            errors++;
            $display("FAIL read_pop: valid=%b data=%h, required 0 00000000", bus.m_rb_valid, bus.m_rb_data);
        end
    endtask

    task automatic test_cmd_full();
        logic [31:0] w;
        logic        b;
        for (int i = 0; i < 16; i++) push_cmd(32'h100 + i, 1'b0);
        checks++;
        if (bus.cmd_level !== 5'd15 || bus.s_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill16: level=%0d ready=%b, required 15 1", bus.cmd_level, bus.s_cmd_ready);
        end
        push_cmd(32'h110, 1'b0);
        checks++;
        if (bus.cmd_level !== 5'd16 || bus.s_cmd_ready !== 1'b0 || bus.m_spi_wvalid !== 1'b1 ||
            bus.m_spi_wdata !== 32'h100) begin
            errors++;
            $display("FAIL fill17: level=%0d ready=%b wvalid=%b wdata=%h, required 16 0 1 00000100",
                     bus.cmd_level, bus.s_cmd_ready, bus.m_spi_wvalid, bus.m_spi_wdata);
        end
        bus.s_cmd_data  = 32'h111;
        bus.s_cmd_rd    = 1'b0;
        bus.s_cmd_valid = 1'b1;
        repeat (3) @(negedge axis_clk);
        checks++;
        if (bus.cmd_level !== 5'd16 || bus.s_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: level=%0d ready=%b, required 16 0", bus.cmd_level, bus.s_cmd_ready);
        end
        fork
            push_cmd(32'h111, 1'b0);
            serve(32'h0, w, b);
        join
        checks++;
        if (w !== 32'h100 || bus.cmd_level !== 5'd16) begin
            errors++;
            $display("FAIL full_accept: word=%h level=%0d, required 00000100 16", w, bus.cmd_level);
        end
        for (int i = 1; i < 18; i++) begin
            serve(32'h0, w, b);
            checks++;
            if (w !== 32'h100 + i) begin
                errors++;
                $display("FAIL drain%0d: got %h, required %h", i, w, 32'h100 + i);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_level !== 5'd0) begin
            errors++;
            $display("FAIL drain_end: busy=%b level=%0d, required 0 0", bus.busy, bus.cmd_level);
        end
    endtask

    task automatic test_rb_full();
        logic [31:0] w;
        logic        b;
        for (int i = 0; i < 9; i++) push_cmd(32'h9000 + i, 1'b1);
        for (int i = 0; i < 8; i++) begin
            serve(32'hD00 + i, w, b);
            checks++;
            if (w !== 32'h9000 + i) begin
                errors++;
                $display("FAIL rb_issue%0d: got %h, required %h", i, w, 32'h9000 + i);
            end
        end
        repeat (5) @(negedge axis_clk);
        checks++;
        if (bus.m_spi_wvalid !== 1'b0 || bus.cmd_level !== 5'd1 || bus.m_rb_valid !== 1'b1 ||
            bus.m_rb_data !== 32'hD00) begin
            errors++;
            $display("FAIL rb_block: wvalid=%b level=%0d rb_valid=%b rb_data=%h, required 0 1 1 00000d00",
                     bus.m_spi_wvalid, bus.cmd_level, bus.m_rb_valid, bus.m_rb_data);
        end
        bus.m_rb_ready = 1'b1;
        @(negedge axis_clk);
        bus.m_rb_ready = 1'b0;
        serve(32'hD08, w, b);
        checks++;
        if (w !== 32'h9008) begin
            errors++;
            $display("FAIL rb_ninth: got %h, required 00009008", w);
        end
        bus.m_rb_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            checks++;
            if (bus.m_rb_valid !== 1'b1 || bus.m_rb_data !== 32'hD00 + i) begin
                errors++;
                $display("FAIL rb_pop%0d: valid=%b data=%h, required 1 %h", i, bus.m_rb_valid, bus.m_rb_data, 32'hD00 + i);
            end
            @(negedge axis_clk);
        end
        bus.m_rb_ready = 1'b0;
        checks++;
        if (bus.m_rb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rb_empty: valid=%b, required 0", bus.m_rb_valid);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        logic        b;
        push_cmd(32'h0000_00E1, 1'b1);
        wait_wvalid();
        bus.m_spi_wready = 1'b1;
        @(negedge axis_clk);
        bus.m_spi_wready = 1'b0;
        repeat (14) @(negedge axis_clk);
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.spi_done_ready !== 1'b1) begin
            errors++;
            $display("FAIL wd_cycle15: err=%b done_ready=%b, required 0 1", bus.timeout_err, bus.spi_done_ready);
        end
        bus.err_clr = 1'b1;
        @(negedge axis_clk);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.spi_done_ready !== 1'b0 || bus.m_rb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_fire: err=%b done_ready=%b rb_valid=%b, required 1 0 0",
                     bus.timeout_err, bus.spi_done_ready, bus.m_rb_valid);
        end
        push_cmd(32'h0000_00E2, 1'b0);
        serve(32'h0, w, b);
        checks++;
        if (w !== 32'h0000_00E2 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_next: word=%h err=%b, required 000000e2 1", w, bus.timeout_err);
        end
        bus.err_clr = 1'b1;
        @(negedge axis_clk);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: got %b, required 0", bus.timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) push_cmd(32'hF0 + i, 1'b0);
        wait_wvalid();
        bus.m_spi_wready = 1'b1;
        @(negedge axis_clk);
        bus.m_spi_wready = 1'b0;
        checks++;
        if (bus.cmd_level !== 5'd5 || bus.spi_done_ready !== 1'b1 || bus.m_spi_wdata !== 32'hF0) begin
            errors++;
            $display("FAIL pre_reset: level=%0d done_ready=%b wdata=%h, required 5 1 000000f0",
                     bus.cmd_level, bus.spi_done_ready, bus.m_spi_wdata);
        end
        #2 axis_resetn = 1'b0;
        #1 test_reset();
        @(negedge axis_clk);
        axis_resetn = 1'b1;
        repeat (2) @(negedge axis_clk);
        checks++;
        if (bus.cmd_level !== 5'd0 || bus.busy !== 1'b0 || bus.m_spi_wvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: level=%0d busy=%b wvalid=%b, required 0 0 0",
                     bus.cmd_level, bus.busy, bus.m_spi_wvalid);
        end
    endtask

    initial begin
        bus.s_cmd_data     = '0;
        bus.s_cmd_rd       = 1'b0;
        bus.s_cmd_valid    = 1'b0;
        bus.m_spi_wready   = 1'b0;
        bus.spi_rdata      = '0;
        bus.spi_done_valid = 1'b0;
        bus.m_rb_ready     = 1'b0;
        bus.err_clr        = 1'b0;
        repeat (2) @(negedge axis_clk);
        test_reset();
        axis_resetn = 1'b1;
        @(negedge axis_clk);
        test_writes();
        test_read();
        test_cmd_full();
        test_rb_full();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
